// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl: multiplexed seven-segment scanner with a double-buffered
// hex value, leading-zero blanking, per-digit decimal points, 16-level PWM
// brightness and ghost blanking on the first cycle of every digit slot.
module sevenseg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned CLK_DIV    = 50000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [3:0]              bright,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int unsigned         IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned         PSC_W   = $clog2(CLK_DIV);
    localparam logic [PSC_W-1:0]    PSC_MAX = PSC_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]    IDX_MAX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [24:0]         DIV_W   = 25'(CLK_DIV);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{ACTIVE_LOW}};
    localparam logic [6:0]          SEG_OFF = {7{ACTIVE_LOW}};
    localparam logic                DP_OFF  = ACTIVE_LOW;

    // Active-high glyphs, bit order {a,b,c,d,e,f,g}
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_glyph = 7'h7E;
            4'h1:    hex_glyph = 7'h30;
            4'h2:    hex_glyph = 7'h6D;
            4'h3:    hex_glyph = 7'h79;
            4'h4:    hex_glyph = 7'h33;
            4'h5:    hex_glyph = 7'h5B;
            4'h6:    hex_glyph = 7'h5F;
            4'h7:    hex_glyph = 7'h70;
            4'h8:    hex_glyph = 7'h7F;
            4'h9:    hex_glyph = 7'h7B;
            4'hA:    hex_glyph = 7'h77;
            4'hB:    hex_glyph = 7'h1F;
            4'hC:    hex_glyph = 7'h4E;
            4'hD:    hex_glyph = 7'h3D;
            4'hE:    hex_glyph = 7'h4F;
            default: hex_glyph = 7'h47;
        endcase
    endfunction

    logic [4*NUM_DIGITS-1:0] shadow, disp, disp_n;
    logic [PSC_W-1:0]        psc, psc_n;
    logic [IDX_W-1:0]        idx, idx_n;
    logic [24:0]             on_cnt, on_cnt_n, on_calc;
    logic                    psc_wrap, frame_wrap;
    logic                    lz_acc;
    logic [NUM_DIGITS-1:0]   zero_from, blankable, onehot;
    logic [3:0]              sel_nib;
    logic                    sel_blank, sel_dp, an_en;

    // Next-state of the scan counters; outputs are decoded from these next
    // values so the registered pins line up with the registered counters.
    always_comb begin
        psc_wrap   = (psc == PSC_MAX);
        psc_n      = psc_wrap ? '0 : psc + PSC_W'(1);
        frame_wrap = psc_wrap && (idx == IDX_MAX);
        if (frame_wrap)
            idx_n = '0;
        else if (psc_wrap)
            idx_n = idx + IDX_W'(1);
        else
            idx_n = idx;
        disp_n   = frame_wrap ? shadow : disp;
        on_calc  = ((25'(bright) + 25'd1) * DIV_W) >> 4;
        on_cnt_n = (psc == '0) ? on_calc : on_cnt;

        // zero_from[i]: nibbles i..top of the displayed value are all zero
        lz_acc    = 1'b1;
        zero_from = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            lz_acc = lz_acc && (disp_n[4*(NUM_DIGITS-1-k) +: 4] == 4'h0);
            zero_from[NUM_DIGITS-1-k] = lz_acc;
        end
        blankable = zero_from & ~NUM_DIGITS'(1);

        sel_nib   = '0;
        sel_blank = 1'b0;
        sel_dp    = 1'b0;
        onehot    = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (idx_n == IDX_W'(k)) begin
                sel_nib   = disp_n[4*k +: 4];
                sel_blank = blank_lz && blankable[k];
                sel_dp    = dp_mask[k];
                onehot[k] = 1'b1;
            end
        end

        an_en = (psc_n != '0) && (25'(psc_n) < on_cnt_n);
    end

    // Scan counters, value buffers and brightness threshold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc        <= '0;
            idx        <= '0;
            shadow     <= '0;
            disp       <= '0;
            on_cnt     <= '0;
            frame_done <= 1'b0;
        end else begin
            psc        <= psc_n;
            idx        <= idx_n;
            disp       <= disp_n;
            on_cnt     <= on_cnt_n;
            frame_done <= frame_wrap;
            if (load)
                shadow <= value;
        end
    end

    // Registered display pins with polarity applied
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= DP_OFF;
        end else begin
            an  <= (an_en ? onehot : '0) ^ AN_OFF;
            seg <= (sel_blank ? 7'h00 : hex_glyph(sel_nib)) ^ SEG_OFF;
            dp  <= (sel_dp && !sel_blank) ^ DP_OFF;
        end
    end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// tb_sevenseg_scan_ctrl: randomized self-checking bench for sevenseg_scan_ctrl
// (4 digits, 32 clocks per slot, active-low pins).
module tb_sevenseg_scan_ctrl;

    localparam int N     = 4;
    localparam int DIV   = 32;
    localparam int FRAME = N * DIV;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] value = '0;
    logic        load = 1'b0, blank_lz = 1'b0;
    logic [3:0]  dp_mask = '0, bright = 4'hF;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp, frame_done;

    int checks = 0;
    int errors = 0;

    // Reference model: time since reset release plus display buffers
    int          m_t;
    int          m_oncnt;
    logic [15:0] m_shadow, m_disp;
    logic        m_blank;
    logic [3:0]  m_dpm;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_fd;

    // Standard hex glyphs, active-high {a,b,c,d,e,f,g}
    logic [6:0] glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    always #5 clk = ~clk;

    sevenseg_scan_ctrl #(.NUM_DIGITS(N), .CLK_DIV(DIV), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load), .blank_lz(blank_lz),
        .dp_mask(dp_mask), .bright(bright), .an(an), .seg(seg), .dp(dp),
        .frame_done(frame_done)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: no finish by time limit, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic model_reset();
        m_t = 0; m_oncnt = 0; m_shadow = '0; m_disp = '0; m_blank = 1'b0; m_dpm = '0;
    endtask

    // One clock: the model applies the same inputs the DUT sees at the edge
    task automatic tick();
        @(posedge clk);
        if (m_t % DIV == 0) m_oncnt = ((int'(bright) + 1) * DIV) / 16;
        m_t++;
        if (m_t % FRAME == 0) m_disp = m_shadow;
        if (load) m_shadow = value;
        m_blank = blank_lz;
        m_dpm   = dp_mask;
        @(negedge clk);
    endtask

    task automatic expect_now();
        int psc, d;
        bit blank;
        psc   = m_t % DIV;
        d     = (m_t / DIV) % N;
        blank = (d > 0) && m_blank && ((m_disp >> (4 * d)) == 16'h0);
        if (m_t == 0) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
        end else begin
            e_an  = (psc >= 1 && psc < m_oncnt) ? ~(4'b1 << d) : 4'hF;
            e_seg = blank ? 7'h7F : ~glyph[m_disp[4*d +: 4]];
            e_dp  = !(m_dpm[d] && !blank);
            e_fd  = (m_t % FRAME == 0);
        end
    endtask

    function automatic logic [3:0] unglyph(input logic [6:0] s);
        unglyph = 'x;
        for (int k = 0; k < 16; k++)
            if ((~glyph[k]) == s) unglyph = 4'(k);
    endfunction

    task automatic test_reset();
        int pulses = 0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (an !== 4'hF)  begin errors++; $display("FAIL reset_an an=%h exp=f", an); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg seg=%h exp=7f", seg); end
        checks++; if (dp !== 1'b1)   begin errors++; $display("FAIL reset_dp dp=%b exp=1", dp); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd fd=%b exp=0", frame_done); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        checks++; if (an !== 4'hF) begin errors++; $display("FAIL rel_cycle1_an an=%h exp=f", an); end
        tick();
        checks++; if (an !== 4'hE) begin errors++; $display("FAIL rel_cycle2_an an=%h exp=e", an); end
        for (int c = 0; c < 300; c++) begin
            tick();
            expect_now();
            checks++; if (an !== e_an)   begin errors++; $display("FAIL rst_an t=%0d an=%h exp=%h", m_t, an, e_an); end
            checks++; if (seg !== e_seg) begin errors++; $display("FAIL rst_seg t=%0d seg=%h exp=%h", m_t, seg, e_seg); end
            checks++; if (dp !== e_dp)   begin errors++; $display("FAIL rst_dp t=%0d dp=%b exp=%b", m_t, dp, e_dp); end
            checks++; if (frame_done !== e_fd) begin errors++; $display("FAIL rst_fd t=%0d fd=%b exp=%b", m_t, frame_done, e_fd); end
            if (frame_done === 1'b1) pulses++;
        end
        checks++; if (pulses != 2) begin errors++; $display("FAIL frame_pulse_count got=%0d exp=2", pulses); end
    endtask

    task automatic test_decode();
        logic [15:0] shown;
        int low;
        bright = 4'hF; blank_lz = 1'b0; dp_mask = 4'b0101;
        value = 16'h1A30; load = 1'b1; tick(); load = 1'b0;
        for (int c = 0; c < FRAME && (m_t % FRAME) != 0; c++) tick();
        shown = '0; low = 0;
        for (int c = 0; c < FRAME; c++) begin
            expect_now();
            checks++; if (an !== e_an)   begin errors++; $display("FAIL dec_an t=%0d an=%h exp=%h", m_t, an, e_an); end
            checks++; if (seg !== e_seg) begin errors++; $display("FAIL dec_seg t=%0d seg=%h exp=%h", m_t, seg, e_seg); end
            checks++; if (dp !== e_dp)   begin errors++; $display("FAIL dec_dp t=%0d dp=%b exp=%b", m_t, dp, e_dp); end
            checks++; if (frame_done !== e_fd) begin errors++; $display("FAIL dec_fd t=%0d fd=%b exp=%b", m_t, frame_done, e_fd); end
            if (m_t % DIV == 1) shown[4*((m_t / DIV) % N) +: 4] = unglyph(seg);
            if (an !== 4'hF) low++;
            tick();
        end
        checks++; if (shown !== 16'h1A30) begin errors++; $display("FAIL dec_shown got=%h exp=1a30", shown); end
        checks++; if (low != 124) begin errors++; $display("FAIL dec_on_cycles got=%0d exp=124", low); end
        for (int r = 0; r < 3; r++) begin
            value = 16'($urandom); dp_mask = 4'($urandom);
            load = 1'b1; tick(); load = 1'b0;
            for (int c = 0; c < 2 * FRAME; c++) begin
                tick();
                expect_now();
                checks++; if (an !== e_an)   begin errors++; $display("FAIL rnd_an t=%0d an=%h exp=%h", m_t, an, e_an); end
                checks++; if (seg !== e_seg) begin errors++; $display("FAIL rnd_seg t=%0d seg=%h exp=%h", m_t, seg, e_seg); end
                checks++; if (dp !== e_dp)   begin errors++; $display("FAIL rnd_dp t=%0d dp=%b exp=%b", m_t, dp, e_dp); end
                checks++; if (frame_done !== e_fd) begin errors++; $display("FAIL rnd_fd t=%0d fd=%b exp=%b", m_t, frame_done, e_fd); end
                if ($urandom_range(0, 15) == 0) dp_mask = 4'($urandom);
            end
        end
    endtask

    task automatic test_blanking();
        logic [6:0] s [4];
        logic [3:0] dps;
        int lit_other;
        bright = 4'hF; blank_lz = 1'b1; dp_mask = 4'hF;
        value = 16'h0050; load = 1'b1; tick(); load = 1'b0;
        for (int c = 0; c < FRAME && (m_t % FRAME) != 0; c++) tick();
        dps = '0;
        for (int c = 0; c < FRAME; c++) begin
            expect_now();
            checks++; if (seg !== e_seg) begin errors++; $display("FAIL blk_seg t=%0d seg=%h exp=%h", m_t, seg, e_seg); end
            checks++; if (dp !== e_dp)   begin errors++; $display("FAIL blk_dp t=%0d dp=%b exp=%b", m_t, dp, e_dp); end
            if (m_t % DIV == 1) begin
                s[(m_t / DIV) % N]   = seg;
                dps[(m_t / DIV) % N] = dp;
            end
            tick();
        end
        checks++; if (s[3] !== 7'h7F) begin errors++; $display("FAIL blk_d3 seg=%h exp=7f", s[3]); end
        checks++; if (s[2] !== 7'h7F) begin errors++; $display("FAIL blk_d2 seg=%h exp=7f", s[2]); end
        checks++; if (s[1] !== 7'h24) begin errors++; $display("FAIL blk_d1 seg=%h exp=24", s[1]); end
        checks++; if (s[0] !== 7'h01) begin errors++; $display("FAIL blk_d0 seg=%h exp=01", s[0]); end
        checks++; if (dps !== 4'b1100) begin errors++; $display("FAIL blk_dp_pattern got=%b exp=1100", dps); end
        value = 16'h0000; load = 1'b1; tick(); load = 1'b0;
        for (int c = 0; c < FRAME && (m_t % FRAME) != 0; c++) tick();
        lit_other = 0;
        for (int c = 0; c < FRAME; c++) begin
            if ((m_t / DIV) % N != 0 && seg !== 7'h7F) lit_other++;
            if ((m_t / DIV) % N == 0 && m_t % DIV == 1) s[0] = seg;
            tick();
        end
        checks++; if (lit_other != 0) begin errors++; $display("FAIL blk_zero_lit got=%0d exp=0", lit_other); end
        checks++; if (s[0] !== 7'h01) begin errors++; $display("FAIL blk_zero_d0 seg=%h exp=01", s[0]); end
        for (int r = 0; r < 3; r++) begin
            value = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
            dp_mask = 4'($urandom);
            load = 1'b1; tick(); load = 1'b0;
            for (int c = 0; c < 2 * FRAME; c++) begin
                tick();
                expect_now();
                checks++; if (an !== e_an)   begin errors++; $display("FAIL blkr_an t=%0d an=%h exp=%h", m_t, an, e_an); end
                checks++; if (seg !== e_seg) begin errors++; $display("FAIL blkr_seg t=%0d seg=%h exp=%h", m_t, seg, e_seg); end
                checks++; if (dp !== e_dp)   begin errors++; $display("FAIL blkr_dp t=%0d dp=%b exp=%b", m_t, dp, e_dp); end
                checks++; if (frame_done !== e_fd) begin errors++; $display("FAIL blkr_fd t=%0d fd=%b exp=%b", m_t, frame_done, e_fd); end
                if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
            end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_brightness();
        int levels [2] = '{0, 7};
        int on_exp [2] = '{4, 60};
        int low;
        blank_lz = 1'b0; dp_mask = '0;
        for (int b = 0; b < 2; b++) begin
            bright = 4'(levels[b]);
            for (int c = 0; c < 64; c++) tick();
            low = 0;
            for (int c = 0; c < FRAME; c++) begin
                tick();
                expect_now();
                checks++; if (an !== e_an) begin errors++; $display("FAIL br_an t=%0d an=%h exp=%h", m_t, an, e_an); end
                if (an !== 4'hF) low++;
            end
            checks++; if (low != on_exp[b]) begin errors++; $display("FAIL br_on_cycles bright=%0d got=%0d exp=%0d", levels[b], low, on_exp[b]); end
        end
        for (int c = 0; c < 2 * FRAME; c++) begin
            if ($urandom_range(0, 7) == 0) bright = 4'($urandom);
            tick();
            expect_now();
            checks++; if (an !== e_an) begin errors++; $display("FAIL brr_an t=%0d an=%h exp=%h", m_t, an, e_an); end
            checks++; if (seg !== e_seg) begin errors++; $display("FAIL brr_seg t=%0d seg=%h exp=%h", m_t, seg, e_seg); end
        end
        bright = 4'hF;
    endtask

    task automatic test_load_on_wrap();
        logic [15:0] shown_a, shown_b;
        bright = 4'hF; blank_lz = 1'b0;
        value = 16'h1234; load = 1'b1; tick(); load = 1'b0;
        for (int c = 0; c < FRAME && ((m_t + 1) % FRAME) != 0; c++) tick();
        value = 16'hBEEF; load = 1'b1; tick(); load = 1'b0;
        shown_a = '0; shown_b = '0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            expect_now();
            checks++; if (seg !== e_seg) begin errors++; $display("FAIL wrap_seg t=%0d seg=%h exp=%h", m_t, seg, e_seg); end
            checks++; if (frame_done !== e_fd) begin errors++; $display("FAIL wrap_fd t=%0d fd=%b exp=%b", m_t, frame_done, e_fd); end
            if (m_t % DIV == 1) begin
                if (c < FRAME) shown_a[4*((m_t / DIV) % N) +: 4] = unglyph(seg);
                else           shown_b[4*((m_t / DIV) % N) +: 4] = unglyph(seg);
            end
            tick();
        end
        checks++; if (shown_a !== 16'h1234) begin errors++; $display("FAIL wrap_first_frame got=%h exp=1234", shown_a); end
        checks++; if (shown_b !== 16'hBEEF) begin errors++; $display("FAIL wrap_second_frame got=%h exp=beef", shown_b); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] v [3];
        logic [15:0] shown;
        for (int c = 0; c < FRAME && (m_t % FRAME) != 0; c++) tick();
        repeat (10) tick();
        v[0] = 16'($urandom); v[2] = 16'($urandom); v[1] = ~v[2];
        for (int k = 0; k < 3; k++) begin
            value = v[k]; load = 1'b1; tick();
        end
        load = 1'b0; value = 16'($urandom);
        for (int c = 0; c < FRAME && (m_t % FRAME) != 0; c++) tick();
        shown = '0;
        for (int c = 0; c < FRAME; c++) begin
            expect_now();
            checks++; if (seg !== e_seg) begin errors++; $display("FAIL b2b_seg t=%0d seg=%h exp=%h", m_t, seg, e_seg); end
            if (m_t % DIV == 1) shown[4*((m_t / DIV) % N) +: 4] = unglyph(seg);
            tick();
        end
        checks++; if (shown !== v[2]) begin errors++; $display("FAIL b2b_last_wins got=%h exp=%h", shown, v[2]); end
    endtask

    task automatic test_reset_mid();
        bright = 4'hF; blank_lz = 1'b0; dp_mask = '0;
        value = 16'hC0DE; load = 1'b1; tick(); load = 1'b0;
        for (int c = 0; c < FRAME && (m_t % FRAME) != 0; c++) tick();
        for (int c = 0; c < FRAME && (m_t % FRAME) != 2 * DIV + 10; c++) tick();
        checks++; if (an !== 4'b1011) begin errors++; $display("FAIL mid_pre_an an=%h exp=b", an); end
        checks++; if (seg !== 7'h01)  begin errors++; $display("FAIL mid_pre_seg seg=%h exp=01", seg); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (an !== 4'hF)   begin errors++; $display("FAIL mid_rst_an an=%h exp=f", an); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL mid_rst_seg seg=%h exp=7f", seg); end
        checks++; if (dp !== 1'b1)   begin errors++; $display("FAIL mid_rst_dp dp=%b exp=1", dp); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL mid_rst_fd fd=%b exp=0", frame_done); end
        @(posedge clk); #1;
        checks++; if (an !== 4'hF) begin errors++; $display("FAIL mid_hold_an an=%h exp=f", an); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        tick();
        checks++; if (an !== 4'hE)   begin errors++; $display("FAIL mid_restart_an an=%h exp=e", an); end
        checks++; if (seg !== 7'h01) begin errors++; $display("FAIL mid_restart_seg seg=%h exp=01", seg); end
        for (int c = 0; c < FRAME + 2; c++) begin
            tick();
            expect_now();
            checks++; if (an !== e_an)   begin errors++; $display("FAIL midr_an t=%0d an=%h exp=%h", m_t, an, e_an); end
            checks++; if (seg !== e_seg) begin errors++; $display("FAIL midr_seg t=%0d seg=%h exp=%h", m_t, seg, e_seg); end
            checks++; if (frame_done !== e_fd) begin errors++; $display("FAIL midr_fd t=%0d fd=%b exp=%b", m_t, frame_done, e_fd); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_decode();
        test_blanking();
        test_brightness();
        test_load_on_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
